// File: rtl/spi_seq_pkg.sv
// Shared types and default sizing for the SPI burst sequencer.
// States, default parameter values and a counter-width helper.
package spi_seq_pkg;

    localparam int DEF_MAX_LEN      = 16;
    localparam int DEF_GAP_CLKS     = 4;
    localparam int DEF_TIMEOUT_CLKS = 20000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        GAP,
        FINISH
    } seq_state_e;

    // Width of a down-counter that must be able to hold max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_burst_seq_if.sv
// Bus between a burst requester and the sequencer, including the SPI master side.
// master = requester/SPI-master side, slave = the sequencer itself.
interface spi_burst_seq_if #(
    parameter int MAX_LEN = spi_seq_pkg::DEF_MAX_LEN
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             start;
    logic [LEN_W-1:0] len;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic             m_inicio;
    logic [7:0]       m_tx_byte;
    logic             m_rx_dv;
    logic [7:0]       m_rx_byte;
    logic             cs_n;

    modport master (
        output start, len, tx_data, tx_valid, m_rx_dv, m_rx_byte,
        input  tx_ready, rx_data, rx_valid, busy, done, err,
               m_inicio, m_tx_byte, cs_n
    );

    modport slave (
        input  start, len, tx_data, tx_valid, m_rx_dv, m_rx_byte,
        output tx_ready, rx_data, rx_valid, busy, done, err,
               m_inicio, m_tx_byte, cs_n
    );

endinterface

// File: rtl/spi_seq_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
// Load has priority over decrement.
module spi_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_burst_seq.sv
// Byte-burst sequencer in front of an SPI master; owns chip select for the burst.
// Define SPI_SEQ_TIMEOUT_EN to build in the per-byte WAIT watchdog (TIMEOUT_CLKS).
//
// state  | meaning
// IDLE   | waiting for start, cs_n high
// LOAD   | tx_ready high, waiting for next byte
// SEND   | m_inicio pulse to the SPI master
// WAIT   | waiting for m_rx_dv from the master
// GAP    | inter-byte idle with cs_n held low
// FINISH | last byte received; done/cs_n release follow
module spi_burst_seq
    import spi_seq_pkg::*;
#(
    parameter int MAX_LEN      = DEF_MAX_LEN,
    parameter int GAP_CLKS     = DEF_GAP_CLKS,
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic           Clk,
    input  logic           rst,
    spi_burst_seq_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    // Counter is sized for both uses so its width does not depend on the build.
    localparam int CNT_MAX = (GAP_CLKS > TIMEOUT_CLKS) ? GAP_CLKS : TIMEOUT_CLKS;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int GAP_LD  = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TO_LD   = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0;
`endif

    seq_state_e       state_q;
    logic [LEN_W-1:0] remaining_q;
    logic [LEN_W-1:0] remaining_d;
    logic             tx_ready_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             m_inicio_q;
    logic [7:0]       m_tx_byte_q;
    logic             cs_n_q;

    logic             len_ok;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    assign len_ok = (bus.len != '0) && (bus.len <= LEN_W'(MAX_LEN));

    always_comb begin
        remaining_d = remaining_q - LEN_W'(1);
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_val     = '0;
        case (state_q)
`ifdef SPI_SEQ_TIMEOUT_EN
            SEND: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(TO_LD);
            end
`endif
            WAIT: begin
                if (bus.m_rx_dv) begin
                    if ((remaining_d != '0) && (GAP_CLKS > 0)) begin
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(GAP_LD);
                    end
                end else begin
`ifdef SPI_SEQ_TIMEOUT_EN
                    cnt_dec = 1'b1;
`endif
                end
            end
            GAP:     cnt_dec = 1'b1;
            default: cnt_dec = 1'b0;
        endcase
    end

    spi_seq_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (Clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            tx_ready_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            m_inicio_q  <= 1'b0;
            m_tx_byte_q <= 8'h00;
            cs_n_q      <= 1'b1;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            m_inicio_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (len_ok) begin
                            remaining_q <= bus.len;
                            busy_q      <= 1'b1;
                            cs_n_q      <= 1'b0;
                            tx_ready_q  <= 1'b1;
                            state_q     <= LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.tx_valid) begin
                        m_tx_byte_q <= bus.tx_data;
                        tx_ready_q  <= 1'b0;
                        m_inicio_q  <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: state_q <= WAIT;
                WAIT: begin
                    if (bus.m_rx_dv) begin
                        rx_data_q   <= bus.m_rx_byte;
                        rx_valid_q  <= 1'b1;
                        remaining_q <= remaining_d;
                        if (remaining_d == '0) begin
                            state_q <= FINISH;
                        end else if (GAP_CLKS == 0) begin
                            tx_ready_q <= 1'b1;
                            state_q    <= LOAD;
                        end else begin
                            state_q <= GAP;
                        end
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else if (cnt_zero) begin
                        err_q   <= 1'b1;
                        cs_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`endif
                end
                GAP: begin
                    if (cnt_zero) begin
                        tx_ready_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                // done lands one cycle after the last rx_valid
                FINISH: begin
                    done_q  <= 1'b1;
                    cs_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready  = tx_ready_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.m_inicio  = m_inicio_q;
    assign bus.m_tx_byte = m_tx_byte_q;
    assign bus.cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_burst_seq.sv
// Directed bench for spi_burst_seq with a simple SPI-master responder and tx feeder.
// Build with SPI_SEQ_TIMEOUT_EN to exercise the watchdog instead of the indefinite wait.
module tb_spi_burst_seq;
    localparam int MAXL = 16;
    localparam int GAPC = 4;
    localparam int TOC  = 50;

    logic Clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;

    spi_burst_seq_if #(.MAX_LEN(MAXL)) bus();

    spi_burst_seq #(
        .MAX_LEN      (MAXL),
        .GAP_CLKS     (GAPC),
        .TIMEOUT_CLKS (TOC)
    ) dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge Clk);
            cyc++;
        end
    end

    int         inicio_cyc[$];
    int         rx_cyc[$];
    int         done_cyc[$];
    int         err_cyc[$];
    int         rdy_cyc[$];
    logic [7:0] rx_log[$];
    logic [7:0] mtx_log[$];
    int         cs_bad;
    int         overlap;
    int         n_take;
    logic       take_pend;
    logic [7:0] tx_tbl[8];
    logic [7:0] resp_tbl[8];
    int         tx_base;
    int         resp_base;
    int         slave_limit;
    int         n_resp;

    // Monitor plus tx feeder: next byte is presented once the previous one was taken.
    initial begin
        cs_bad = 0; overlap = 0; n_take = 0; take_pend = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h00;
        forever begin
            @(negedge Clk);
            if (take_pend) n_take++;
            take_pend = !rst && bus.tx_ready && bus.tx_valid;
            if (!rst) begin
                if (bus.m_inicio) begin
                    inicio_cyc.push_back(cyc);
                    mtx_log.push_back(bus.m_tx_byte);
                end
                if (bus.rx_valid) begin
                    rx_cyc.push_back(cyc);
                    rx_log.push_back(bus.rx_data);
                end
                if (bus.done) done_cyc.push_back(cyc);
                if (bus.err) err_cyc.push_back(cyc);
                if (bus.tx_ready) rdy_cyc.push_back(cyc);
                if (bus.busy == bus.cs_n) cs_bad++;
                if (bus.done && bus.rx_valid) overlap++;
            end
            bus.tx_data = tx_tbl[3'((n_take - tx_base) % 8)];
        end
    end

    // SPI master model: answers each m_inicio two cycles later, up to slave_limit bytes.
    initial begin
        bus.m_rx_dv = 1'b0; bus.m_rx_byte = 8'h00; n_resp = 0;
        forever begin
            @(negedge Clk);
            if (!rst && bus.m_inicio && (n_resp < slave_limit)) begin
                repeat (2) @(negedge Clk);
                bus.m_rx_byte = resp_tbl[3'((n_resp - resp_base) % 8)];
                bus.m_rx_dv   = 1'b1;
                @(negedge Clk);
                bus.m_rx_dv = 1'b0;
                n_resp++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    task automatic start_burst(input int l, output int s);
        @(negedge Clk);
        bus.start = 1'b1;
        bus.len   = 5'(l);
        s = cyc;
        @(negedge Clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge Clk);
        tests++; if (bus.cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b want 1", bus.cs_n); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL reset_tx_ready: got %b want 0", bus.tx_ready); end
        tests++; if ({bus.rx_valid, bus.done, bus.err, bus.m_inicio} !== 4'b0000) begin
            fails++; $display("FAIL reset_pulses: got %b want 0000", {bus.rx_valid, bus.done, bus.err, bus.m_inicio}); end
        tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        tests++; if (bus.m_tx_byte !== 8'h00) begin fails++; $display("FAIL reset_m_tx_byte: got %h want 00", bus.m_tx_byte); end
        rst = 1'b0;
        repeat (3) @(negedge Clk);
        tests++; if ({bus.busy, bus.cs_n} !== 2'b01) begin fails++; $display("FAIL post_reset_idle: got busy/cs_n %b want 01", {bus.busy, bus.cs_n}); end
    endtask

    task automatic test_burst;
        logic [7:0] exp_tx[3];
        logic [7:0] exp_rx[3];
        int s, i0, r0, d0, m0, c0, o0, e0;
        exp_tx[0] = 8'hA5; exp_tx[1] = 8'h3C; exp_tx[2] = 8'hFF;
        exp_rx[0] = 8'h11; exp_rx[1] = 8'h22; exp_rx[2] = 8'h33;
        for (int k = 0; k < 3; k++) begin tx_tbl[k] = exp_tx[k]; resp_tbl[k] = exp_rx[k]; end
        tx_base = n_take; resp_base = n_resp; slave_limit = n_resp + 3;
        i0 = inicio_cyc.size(); r0 = rx_log.size(); d0 = done_cyc.size();
        m0 = mtx_log.size(); c0 = cs_bad; o0 = overlap; e0 = err_cyc.size();
        start_burst(3, s);
        for (int k = 0; k < 300 && done_cyc.size() == d0; k++) @(negedge Clk);
        repeat (3) @(negedge Clk);
        tests++; if (done_cyc.size() - d0 != 1) begin fails++; $display("FAIL burst_done_count: got %0d want 1", done_cyc.size() - d0); end
        tests++; if (inicio_cyc.size() - i0 != 3) begin fails++; $display("FAIL burst_inicio_count: got %0d want 3", inicio_cyc.size() - i0); end
        if (inicio_cyc.size() > i0) begin
            tests++; if (inicio_cyc[i0] - s != 2) begin fails++; $display("FAIL burst_latency: got %0d want 2", inicio_cyc[i0] - s); end
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (mtx_log.size() <= m0 + k || mtx_log[m0 + k] !== exp_tx[k]) begin
                fails++; $display("FAIL burst_m_tx_byte%0d: got %h want %h", k, (mtx_log.size() > m0 + k) ? mtx_log[m0 + k] : 8'hxx, exp_tx[k]);
            end
            tests++;
            if (rx_log.size() <= r0 + k || rx_log[r0 + k] !== exp_rx[k]) begin
                fails++; $display("FAIL burst_rx_data%0d: got %h want %h", k, (rx_log.size() > r0 + k) ? rx_log[r0 + k] : 8'hxx, exp_rx[k]);
            end
        end
        if (done_cyc.size() > d0 && rx_cyc.size() >= r0 + 3) begin
            tests++; if (done_cyc[d0] - rx_cyc[r0 + 2] != 1) begin
                fails++; $display("FAIL burst_done_after_rx: got %0d cycles want 1", done_cyc[d0] - rx_cyc[r0 + 2]); end
        end
        tests++; if (overlap != o0) begin fails++; $display("FAIL burst_done_rx_overlap: got %0d want 0", overlap - o0); end
        tests++; if (cs_bad != c0) begin fails++; $display("FAIL burst_cs_n_vs_busy: got %0d bad cycles want 0", cs_bad - c0); end
        tests++; if (err_cyc.size() != e0) begin fails++; $display("FAIL burst_no_err: got %0d errs want 0", err_cyc.size() - e0); end
        tests++; if ({bus.busy, bus.cs_n} !== 2'b01) begin fails++; $display("FAIL burst_end_idle: got busy/cs_n %b want 01", {bus.busy, bus.cs_n}); end
    endtask

    task automatic test_len_err;
        int lens[2];
        int s, e0, i0, low;
        lens[0] = 0; lens[1] = MAXL + 1;
        for (int t = 0; t < 2; t++) begin
            e0 = err_cyc.size(); i0 = inicio_cyc.size(); low = 0;
            start_burst(lens[t], s);
            for (int k = 0; k < 5; k++) begin
                if (bus.cs_n !== 1'b1) low++;
                @(negedge Clk);
            end
            tests++; if (err_cyc.size() - e0 != 1) begin fails++; $display("FAIL len%0d_err_count: got %0d want 1", lens[t], err_cyc.size() - e0); end
            if (err_cyc.size() > e0) begin
                tests++; if (err_cyc[e0] - s != 1) begin fails++; $display("FAIL len%0d_err_timing: got %0d want 1", lens[t], err_cyc[e0] - s); end
            end
            tests++; if (inicio_cyc.size() != i0) begin fails++; $display("FAIL len%0d_no_inicio: got %0d want 0", lens[t], inicio_cyc.size() - i0); end
            tests++; if (low != 0 || bus.busy !== 1'b0) begin fails++; $display("FAIL len%0d_cs_idle: got %0d low cycles busy %b want 0/0", lens[t], low, bus.busy); end
        end
    endtask

    task automatic test_gap;
        int s, x0, y0, d0, c0;
        tx_tbl[0] = 8'h5A; tx_tbl[1] = 8'hC3;
        resp_tbl[0] = 8'h44; resp_tbl[1] = 8'h55;
        tx_base = n_take; resp_base = n_resp; slave_limit = n_resp + 2;
        x0 = rx_cyc.size(); y0 = rdy_cyc.size(); d0 = done_cyc.size(); c0 = cs_bad;
        start_burst(2, s);
        for (int k = 0; k < 300 && done_cyc.size() == d0; k++) @(negedge Clk);
        repeat (2) @(negedge Clk);
        tests++; if (done_cyc.size() - d0 != 1) begin fails++; $display("FAIL gap_done_count: got %0d want 1", done_cyc.size() - d0); end
        if (rx_cyc.size() > x0 && rdy_cyc.size() > y0 + 1) begin
            tests++; if (rdy_cyc[y0 + 1] - rx_cyc[x0] != GAPC) begin
                fails++; $display("FAIL gap_length: got %0d want %0d", rdy_cyc[y0 + 1] - rx_cyc[x0], GAPC); end
        end else begin
            tests++; fails++; $display("FAIL gap_events: got rx %0d ready %0d want 1/2", rx_cyc.size() - x0, rdy_cyc.size() - y0);
        end
        tests++; if (cs_bad != c0) begin fails++; $display("FAIL gap_cs_n_held: got %0d bad cycles want 0", cs_bad - c0); end
    endtask

    task automatic test_start_busy;
        int s, i0, d0, e0;
        tx_tbl[0] = 8'h01; tx_tbl[1] = 8'h02;
        resp_tbl[0] = 8'hA1; resp_tbl[1] = 8'hB2;
        tx_base = n_take; resp_base = n_resp; slave_limit = n_resp + 2;
        i0 = inicio_cyc.size(); d0 = done_cyc.size(); e0 = err_cyc.size();
        start_burst(2, s);
        for (int k = 0; k < 50 && inicio_cyc.size() == i0; k++) @(negedge Clk);
        bus.start = 1'b1; bus.len = 5'd5;
        @(negedge Clk);
        bus.start = 1'b0; bus.len = 5'd0;
        for (int k = 0; k < 300 && done_cyc.size() == d0; k++) @(negedge Clk);
        repeat (30) @(negedge Clk);
        tests++; if (done_cyc.size() - d0 != 1) begin fails++; $display("FAIL busy_start_done: got %0d want 1", done_cyc.size() - d0); end
        tests++; if (inicio_cyc.size() - i0 != 2) begin fails++; $display("FAIL busy_start_inicio: got %0d want 2", inicio_cyc.size() - i0); end
        tests++; if (err_cyc.size() != e0) begin fails++; $display("FAIL busy_start_err: got %0d want 0", err_cyc.size() - e0); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL busy_start_idle: got busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid;
        int s, i0, d0;
        tx_tbl[0] = 8'h10; tx_tbl[1] = 8'h20; tx_tbl[2] = 8'h30;
        resp_tbl[0] = 8'h99;
        tx_base = n_take; resp_base = n_resp; slave_limit = n_resp + 1;
        i0 = inicio_cyc.size(); d0 = done_cyc.size();
        start_burst(3, s);
        for (int k = 0; k < 100 && inicio_cyc.size() < i0 + 2; k++) @(negedge Clk);
        repeat (3) @(negedge Clk);
        tests++; if ({bus.busy, bus.cs_n} !== 2'b10) begin fails++; $display("FAIL rst_mid_pre: got busy/cs_n %b want 10", {bus.busy, bus.cs_n}); end
        rst = 1'b1;
        #1;
        tests++; if (bus.cs_n !== 1'b1) begin fails++; $display("FAIL rst_mid_cs_n: got %b want 1", bus.cs_n); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        tests++; if (bus.m_tx_byte !== 8'h00) begin fails++; $display("FAIL rst_mid_m_tx_byte: got %h want 00", bus.m_tx_byte); end
        @(negedge Clk);
        rst = 1'b0;
        repeat (20) @(negedge Clk);
        tests++; if (done_cyc.size() != d0) begin fails++; $display("FAIL rst_mid_no_done: got %0d want 0", done_cyc.size() - d0); end
        tests++; if (bus.cs_n !== 1'b1) begin fails++; $display("FAIL rst_mid_cs_after: got %b want 1", bus.cs_n); end
    endtask

`ifdef SPI_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int s, i0, d0, e0;
        tx_tbl[0] = 8'h77;
        tx_base = n_take; slave_limit = n_resp;
        i0 = inicio_cyc.size(); d0 = done_cyc.size(); e0 = err_cyc.size();
        start_burst(1, s);
        for (int k = 0; k < 300 && err_cyc.size() == e0; k++) @(negedge Clk);
        repeat (2) @(negedge Clk);
        tests++; if (err_cyc.size() - e0 != 1) begin fails++; $display("FAIL timeout_err_count: got %0d want 1", err_cyc.size() - e0); end
        if (err_cyc.size() > e0 && inicio_cyc.size() > i0) begin
            tests++; if (err_cyc[e0] - inicio_cyc[i0] != TOC + 1) begin
                fails++; $display("FAIL timeout_cycle: got %0d want %0d", err_cyc[e0] - inicio_cyc[i0], TOC + 1); end
        end
        tests++; if ({bus.busy, bus.cs_n} !== 2'b01) begin fails++; $display("FAIL timeout_idle: got busy/cs_n %b want 01", {bus.busy, bus.cs_n}); end
        tests++; if (done_cyc.size() != d0) begin fails++; $display("FAIL timeout_no_done: got %0d want 0", done_cyc.size() - d0); end
    endtask
`else
    task automatic test_no_timeout;
        int s, d0, e0;
        tx_tbl[0] = 8'h77;
        tx_base = n_take; slave_limit = n_resp;
        d0 = done_cyc.size(); e0 = err_cyc.size();
        start_burst(1, s);
        repeat (TOC * 4) @(negedge Clk);
        tests++; if ({bus.busy, bus.cs_n} !== 2'b10) begin fails++; $display("FAIL wait_forever_state: got busy/cs_n %b want 10", {bus.busy, bus.cs_n}); end
        tests++; if (err_cyc.size() != e0) begin fails++; $display("FAIL wait_forever_no_err: got %0d want 0", err_cyc.size() - e0); end
        tests++; if (done_cyc.size() != d0) begin fails++; $display("FAIL wait_forever_no_done: got %0d want 0", done_cyc.size() - d0); end
        rst = 1'b1;
        @(negedge Clk);
        rst = 1'b0;
        repeat (2) @(negedge Clk);
    endtask
`endif

    initial begin
        tests = 0; fails = 0;
        tx_base = 0; resp_base = 0; slave_limit = 0;
        for (int k = 0; k < 8; k++) begin tx_tbl[k] = 8'h00; resp_tbl[k] = 8'h00; end
        bus.start = 1'b0;
        bus.len   = '0;
        rst = 1'b1;
        test_reset;
        test_burst;
        test_len_err;
        test_gap;
        test_start_busy;
        test_reset_mid;
`ifdef SPI_SEQ_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
